wide_add_sequencer: RTL and testbench



---
 rtl/wide_add_pkg.sv | 14 +
 rtl/word_adder.sv | 17 +
 rtl/wide_add_sequencer.sv | 106 ++++++++++
 tb/tb_wide_add_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add/subtract sequencer.
// The state encoding and word width live here so the top and the bench agree on them.
package wide_add_pkg;

    localparam int WORD_W        = 32;
    localparam int WORDS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/word_adder.sv
// Combinational single-word adder slice with carry-in.
// Also flags signed overflow of this word; the sequencer only uses it on the MSB word.
module word_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         ovf
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign ovf     = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);

endmodule

// File: rtl/wide_add_sequencer.sv
// WORDS x W-bit add/subtract streamed one word per cycle through a single word_adder.
// B is inverted at capture and the carry seeded with sub, so subtract costs nothing extra.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// RUN   | one word per cycle, idx selects the word, cy carries between words
// DONE  | result held with out_valid high until out_ready
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = WORDS_DEFAULT,
    parameter int W     = WORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W*WORDS-1:0] a,
    input  logic [W*WORDS-1:0] b,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*WORDS-1:0] sum,
    output logic               carry,
    output logic               overflow
);

    localparam int            IW   = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [WORDS-1:0][W-1:0] a_q;
    logic [WORDS-1:0][W-1:0] b_q;
    logic [WORDS-1:0][W-1:0] sum_q;
    logic [IW-1:0]           idx;
    logic                    cy;
    logic                    carry_q;
    logic                    overflow_q;
    logic [W-1:0]            s_word;
    logic                    co_word;
    logic                    ovf_word;

    word_adder #(.W(W)) u_word_adder (
        .a   (a_q[idx]),
        .b   (b_q[idx]),
        .ci  (cy),
        .s   (s_word),
        .co  (co_word),
        .ovf (ovf_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            idx        <= '0;
            cy         <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_q <= a;
                b_q <= sub ? ~b : b;
                idx <= '0;
                cy  <= sub;
            end else if (state == RUN) begin
                sum_q[idx] <= s_word;
                cy         <= co_word;
                if (idx == LAST) begin
                    carry_q    <= co_word;
                    overflow_q <= ovf_word;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Handshake outputs decode the state register only, never the inputs.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer at WORDS=4: vector table plus
// backpressure, asynchronous reset and mid-RUN reset sequences.
module tb_wide_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 32;
    localparam int N     = W * WORDS;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sub;
        logic [N-1:0] exp_sum;
        logic         exp_c;
        logic         exp_v;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carry;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    vec_t vecs [8];

    wide_add_sequencer #(.WORDS(WORDS), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Accepts one operand set, waits for the result, checks it and releases it.
    task automatic run_op(input vec_t v, input string nm);
        int cyc;
        @(negedge clk);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_in_ready"}, N'(in_ready), N'(1));
        a        = v.a;
        b        = v.b;
        sub      = v.sub;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, N'(cyc), N'(WORDS));
        chk({nm, "_sum"}, sum, v.exp_sum);
        chk({nm, "_carry"}, N'(carry), N'(v.exp_c));
        chk({nm, "_ovf"}, N'(overflow), N'(v.exp_v));
        chk({nm, "_busy"}, N'(in_ready), N'(0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_released"}, N'({out_valid, in_ready}), N'(2'b01));
    endtask

    initial begin
        int cyc;
        logic seen;

        vecs[0] = '{{N{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0};
        vecs[1] = '{128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0,
                    128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0};
        vecs[2] = '{128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
                    128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{128'd5, 128'd7, 1'b1,
                    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{128'd7, 128'd5, 1'b1, 128'd2, 1'b1, 1'b0};
        vecs[5] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1'b1,
                    128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000,
                    128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0,
                    128'd0, 1'b1, 1'b1};
        vecs[7] = '{128'h0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF,
                    128'h0000_0000_0000_0001_FFFF_FFFF_0000_0001, 1'b0,
                    128'h0000_0002_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        #1;
        chk("reset_state", N'({out_valid, in_ready, carry, overflow}), N'(4'b0100));
        chk("reset_sum", sum, '0);
        #12;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held, new operands refused while DONE.
        @(negedge clk);
        a = vecs[1].a; b = vecs[1].b; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_latency", N'(cyc), N'(WORDS));
        a = vecs[0].a; b = vecs[0].b; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_sum%0d", i), sum, vecs[1].exp_sum);
            chk($sformatf("bp_hold_hs%0d", i), N'({out_valid, in_ready}), N'(2'b10));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release", N'({out_valid, in_ready}), N'(2'b01));
        chk("bp_idle_hold", sum, vecs[1].exp_sum);

        // Asynchronous reset between edges with a result in DONE.
        @(negedge clk);
        a = vecs[2].a; b = vecs[2].b; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ar_pre_ovf", N'(overflow), N'(1));
        #2 rst = 1'b1;
        #1;
        chk("ar_flags", N'({out_valid, in_ready, carry, overflow}), N'(4'b0100));
        chk("ar_sum", sum, '0);
        @(negedge clk);
        rst = 1'b0;

        // Reset pulsed mid-RUN at idx=2.
        @(negedge clk);
        a = vecs[0].a; b = vecs[0].b; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_idx", N'(dut.idx), N'(2));
        rst = 1'b1;
        #1;
        chk("mr_in_ready", N'(in_ready), N'(1));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mr_no_out_valid", N'(seen), N'(0));
        run_op(vecs[7], "mr_next");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
